// File: rtl/adder.sv
// Registered two's-complement adder with 4-bit carry-lookahead groups.
// The sum and carry/overflow/zero/negative status are registered; valid
// marks the cycle after an enabled sample. WIDTH must be a multiple of 4.
module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] add_in1,
  input  logic [WIDTH-1:0] add_in2,
  output logic [WIDTH-1:0] add_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             valid
);

  localparam int unsigned GROUPS = WIDTH / 4;

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             sum_carry;
  logic             sum_overflow;
  logic             sum_zero;
  logic             sum_negative;

  // Per-bit generate/propagate terms.
  always_comb begin
    gen  = add_in1 & add_in2;
    prop = add_in1 ^ add_in2;
  end

  // Cascaded 4-bit lookahead groups: each group resolves its internal and
  // outgoing carries from its own g/p and the group carry-in.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b0;
    for (int unsigned grp = 0; grp < GROUPS; grp++) begin
      carry[grp*4+1] = gen[grp*4]
                     | (prop[grp*4] & carry[grp*4]);
      carry[grp*4+2] = gen[grp*4+1]
                     | (prop[grp*4+1] & gen[grp*4])
                     | (prop[grp*4+1] & prop[grp*4] & carry[grp*4]);
      carry[grp*4+3] = gen[grp*4+2]
                     | (prop[grp*4+2] & gen[grp*4+1])
                     | (prop[grp*4+2] & prop[grp*4+1] & gen[grp*4])
                     | (prop[grp*4+2] & prop[grp*4+1] & prop[grp*4] & carry[grp*4]);
      carry[grp*4+4] = gen[grp*4+3]
                     | (prop[grp*4+3] & gen[grp*4+2])
                     | (prop[grp*4+3] & prop[grp*4+2] & gen[grp*4+1])
                     | (prop[grp*4+3] & prop[grp*4+2] & prop[grp*4+1] & gen[grp*4])
                     | (prop[grp*4+3] & prop[grp*4+2] & prop[grp*4+1] & prop[grp*4]
                        & carry[grp*4]);
    end
  end

  // Sum bits and status flags derived from the carry chain.
  always_comb begin
    sum          = prop ^ carry[WIDTH-1:0];
    sum_carry    = carry[WIDTH];
    sum_overflow = carry[WIDTH-1] ^ carry[WIDTH];
    sum_zero     = (sum == '0);
    sum_negative = sum[WIDTH-1];
  end

  // Output registers: capture on enabled edges, hold otherwise; valid
  // follows en one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_out   <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        add_out   <= sum;
        carry_out <= sum_carry;
        overflow  <= sum_overflow;
        zero      <= sum_zero;
        negative  <= sum_negative;
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Directed bench for the registered adder: hand-computed vectors covering
// reset, sign mixes, overflow/carry boundaries, enable hold and async reset.
module tb_adder;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] add_in1;
  logic [31:0] add_in2;
  logic [31:0] add_out;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic        negative;
  logic        valid;

  int unsigned n_vec;
  int unsigned n_err;

  adder #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .add_in1  (add_in1),
    .add_in2  (add_in2),
    .add_out  (add_out),
    .carry_out(carry_out),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_out, input logic e_c,
                         input logic e_ov, input logic e_z, input logic e_n,
                         input logic e_v);
    chk({tag, ".add_out"},   add_out,   e_out);
    chk({tag, ".carry_out"}, {31'd0, carry_out}, {31'd0, e_c});
    chk({tag, ".overflow"},  {31'd0, overflow},  {31'd0, e_ov});
    chk({tag, ".zero"},      {31'd0, zero},      {31'd0, e_z});
    chk({tag, ".negative"},  {31'd0, negative},  {31'd0, e_n});
    chk({tag, ".valid"},     {31'd0, valid},     {31'd0, e_v});
  endtask

  // Drive operands at the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic e);
    @(negedge clk);
    add_in1 = a;
    add_in2 = b;
    en      = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    en      = 1'b0;
    add_in1 = '0;
    add_in2 = '0;
    #3;
    chk_all("reset_idle", 32'd0, 0, 0, 0, 0, 0);

    // Enabled activity during reset is ignored.
    step(32'd5, 32'd5, 1'b1);
    chk_all("reset_en_ignored", 32'd0, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0;

    step(32'd0, 32'd0, 1'b1);
    chk_all("zero_add", 32'd0, 0, 0, 1, 0, 1);

    step(32'd1, 32'd2, 1'b1);
    chk_all("one_plus_two", 32'd3, 0, 0, 0, 0, 1);

    step(32'd10500000, 32'd0, 1'b1);
    chk_all("big_plus_zero", 32'd10500000, 0, 0, 0, 0, 1);

    step(32'hFFFF_FFF6, 32'd5, 1'b1);
    chk_all("neg10_plus5", 32'hFFFF_FFFB, 0, 0, 0, 1, 1);

    step(32'h7FFF_FFFF, 32'd1, 1'b1);
    chk_all("max_pos_plus1", 32'h8000_0000, 0, 1, 0, 1, 1);

    step(32'hFFFF_FFFF, 32'd1, 1'b1);
    chk_all("all_ones_plus1", 32'd0, 1, 0, 1, 0, 1);

    step(32'h8000_0000, 32'h8000_0000, 1'b1);
    chk_all("min_plus_min", 32'd0, 1, 1, 1, 0, 1);

    step(32'h0000_FFFF, 32'd1, 1'b1);
    chk_all("group_ripple", 32'h0001_0000, 0, 0, 0, 0, 1);

    step(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    chk_all("mixed_pattern", 32'h2222_2221, 0, 0, 0, 0, 1);

    step(32'd3, 32'd4, 1'b1);
    chk_all("hold_load", 32'd7, 0, 0, 0, 0, 1);

    step(32'd100, 32'd1, 1'b0);
    chk_all("hold_edge1", 32'd7, 0, 0, 0, 0, 0);

    step(32'd100, 32'd1, 1'b0);
    chk_all("hold_edge2", 32'd7, 0, 0, 0, 0, 0);

    step(32'd100, 32'd1, 1'b1);
    chk_all("hold_release", 32'd101, 0, 0, 0, 0, 1);

    // Flags must hold too, not just the sum.
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk_all("neg_carry_load", 32'hFFFF_FFFE, 1, 0, 0, 1, 1);

    step(32'd0, 32'd0, 1'b0);
    chk_all("flag_hold", 32'hFFFF_FFFE, 1, 0, 0, 1, 0);

    // Asynchronous reset between edges.
    step(32'd1, 32'd2, 1'b1);
    chk_all("pre_reset", 32'd3, 0, 0, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_reset", 32'd0, 0, 0, 0, 0, 0);

    step(32'd20, 32'd22, 1'b1);
    chk_all("reset_held", 32'd0, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0;
    step(32'd20, 32'd22, 1'b1);
    chk_all("post_reset", 32'd42, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
